matmul_feeder: RTL and testbench

MATMUL_FEEDER -- requirements
Module: matmul_feeder

---
 rtl/matmul_feeder.sv | 92 +++++++++
 tb/tb_matmul_feeder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/matmul_feeder.sv
// matmul_feeder: skews captured A/B matrices into systolic-array lanes and sequences one job
module matmul_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 32
) (
   input  logic                                       clk_i,
   input  logic                                       rst_n_i,
   input  logic                                       start_i,
   input  logic [$clog2(BUS_WIDTH/DATA_WIDTH):0]      k_dim_i,
   input  logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)**2-1:0] a_mat_flat_i,
   input  logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)**2-1:0] b_mat_flat_i,
   output logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)-1:0]    a_flat_o,
   output logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)-1:0]    b_flat_o,
   output logic                                       start_operation_o,
   output logic                                       busy_o,
   output logic                                       done_o
);
   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int KW = $clog2(MAX_DIM) + 1;
   localparam int MW = DATA_WIDTH * MAX_DIM * MAX_DIM;
   localparam int LW = DATA_WIDTH * MAX_DIM;
   localparam int CW = $clog2(3 * MAX_DIM) + 1;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FEED  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] k_q, k_eff, k_use;
   logic [MW-1:0] a_q, b_q, a_use, b_use;
   logic [LW-1:0] a_d, b_d;
   logic          accept;
   int            d;

   assign accept = (state_q == IDLE) && start_i;
   assign k_eff  = (k_dim_i == '0 || int'(k_dim_i) > MAX_DIM) ? KW'(MAX_DIM) : k_dim_i;
   // on the accepting edge the captured registers are not loaded yet, so look through to the inputs
   assign k_use  = accept ? k_eff : k_q;
   assign a_use  = accept ? a_mat_flat_i : a_q;
   assign b_use  = accept ? b_mat_flat_i : b_q;

   // sequencing: FEED until the last skewed element leaves, DRAIN while the array settles, one DONE cycle
   always_comb begin
      state_d = accept ? FEED :
                state_q == FEED  ? (int'(cnt_q) == int'(k_q) + MAX_DIM - 2 ? DRAIN : FEED) :
                state_q == DRAIN ? (int'(cnt_q) == int'(k_q) + 2*MAX_DIM - 3 ? DONE : DRAIN) :
                IDLE;
      cnt_d   = accept ? '0 : (state_q != IDLE ? cnt_q + 1'b1 : '0);
   end

   // lane values for the upcoming cycle: row i / column j delayed by its index
   always_comb begin
      a_d = '0;
      b_d = '0;
      d   = 0;
      for (int i = 0; i < MAX_DIM; i++) begin
         d = int'(cnt_d) - i;
         if (state_d == FEED && d >= 0 && d < int'(k_use)) begin
            a_d[i*DATA_WIDTH +: DATA_WIDTH] = a_use[(i*MAX_DIM + d)*DATA_WIDTH +: DATA_WIDTH];
            b_d[i*DATA_WIDTH +: DATA_WIDTH] = b_use[(d*MAX_DIM + i)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // state, cycle counter, captured operands and registered lanes
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         k_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         a_flat_o <= '0;
         b_flat_o <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_flat_o <= a_d;
         b_flat_o <= b_d;
         if (accept) begin
            k_q <= k_eff;
            a_q <= a_mat_flat_i;
            b_q <= b_mat_flat_i;
         end
      end
   end

   assign busy_o            = state_q != IDLE;
   assign start_operation_o = state_q == FEED || state_q == DRAIN;
   assign done_o            = state_q == DONE;
endmodule

// File: tb/tb_matmul_feeder.sv
// tb_matmul_feeder: directed and random jobs checked against a skew-formula reference model
module tb_matmul_feeder;
   localparam int MD = 4;
   localparam int DW = 8;

   logic                 clk = 1'b0;
   logic                 rst_n_i = 1'b0;
   logic                 start_i = 1'b0;
   logic [2:0]           k_dim_i = '0;
   logic [DW*MD*MD-1:0]  a_mat_flat_i = '0;
   logic [DW*MD*MD-1:0]  b_mat_flat_i = '0;
   logic [DW*MD-1:0]     a_flat_o, b_flat_o;
   logic                 start_operation_o, busy_o, done_o;

   int vecs = 0;
   int errs = 0;
   int am[MD][MD];
   int bm[MD][MD];

   matmul_feeder dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .k_dim_i(k_dim_i),
      .a_mat_flat_i(a_mat_flat_i), .b_mat_flat_i(b_mat_flat_i),
      .a_flat_o(a_flat_o), .b_flat_o(b_flat_o),
      .start_operation_o(start_operation_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_a"}, -1, a_flat_o, 0);
      chk({tag, "_b"}, -1, b_flat_o, 0);
      chk({tag, "_ctl"}, -1, {29'd0, start_operation_o, busy_o, done_o}, 0);
   endtask

   task automatic fill_directed();
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) begin
            am[r][c] = 4*r + c + 1;
            bm[r][c] = 16 + 4*r + c + 1;
         end
   endtask

   task automatic fill_random();
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) begin
            am[r][c] = int'($urandom_range(1, 255));
            bm[r][c] = int'($urandom_range(1, 255));
         end
   endtask

   // one job: cycle t is the cycle after the accepting edge; poke_t re-pulses start with junk operands,
   // abort_t pulls reset mid-job; hold keeps start high so the next job follows immediately
   task automatic run_job(input int k_in, input bit hold, input int poke_t, input int abort_t);
      int ke, last;
      logic [31:0] ea, eb;
      ke = (k_in == 0 || k_in > MD) ? MD : k_in;
      last = ke + 2*MD - 2;
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++) begin
            a_mat_flat_i[(r*MD + c)*DW +: DW] = am[r][c][DW-1:0];
            b_mat_flat_i[(r*MD + c)*DW +: DW] = bm[r][c][DW-1:0];
         end
      k_dim_i = 3'(k_in);
      start_i = 1'b1;
      for (int t = 0; t <= last; t++) begin
         @(posedge clk); #1;
         ea = '0;
         eb = '0;
         for (int l = 0; l < MD; l++)
            if (t - l >= 0 && t - l < ke) begin
               ea[l*DW +: DW] = am[l][t-l][DW-1:0];
               eb[l*DW +: DW] = bm[t-l][l][DW-1:0];
            end
         chk("a_lanes", t, a_flat_o, ea);
         chk("b_lanes", t, b_flat_o, eb);
         chk("ctl", t, {29'd0, start_operation_o, busy_o, done_o},
             {29'd0, t <= last - 1, 1'b1, t == last});
         if (!hold) start_i = 1'b0;
         if (t == poke_t) begin
            start_i = 1'b1;
            a_mat_flat_i = {$urandom, $urandom, $urandom, $urandom};
            b_mat_flat_i = {$urandom, $urandom, $urandom, $urandom};
            k_dim_i = 3'd1;
         end
         if (t == abort_t) begin
            rst_n_i = 1'b0;
            start_i = 1'b0;
            #1;
            chk_zero("reset_mid");
            #3;
            rst_n_i = 1'b1;
            return;
         end
      end
      @(posedge clk); #1;
      chk_zero("idle_after");
   endtask

   initial begin
      #12;
      chk_zero("reset");
      @(posedge clk); #1;
      rst_n_i = 1'b1;
      fill_directed();
      run_job(4, 1'b0, -1, -1);
      run_job(2, 1'b0, -1, -1);
      run_job(0, 1'b0, -1, -1);
      run_job(7, 1'b0, -1, -1);
      run_job(4, 1'b0, 3, -1);
      fill_random();
      run_job(3, 1'b1, -1, -1);
      fill_random();
      run_job(1, 1'b0, -1, -1);
      fill_random();
      run_job(4, 1'b0, -1, 5);
      fill_directed();
      run_job(4, 1'b0, -1, -1);
      for (int n = 0; n < 8; n++) begin
         fill_random();
         run_job(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
